// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - sequencer state type and partial-product shift helper for vedic_mul_seq
package vedic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PP0  = 3'd1,
        ST_PP1  = 3'd2,
        ST_PP2  = 3'd3,
        ST_PP3  = 3'd4,
        ST_DONE = 3'd5
    } vedic_seq_state_t;

    // Cross terms (AH*BL, AL*BH) land at W/2, the high term at W, the low term at 0.
    function automatic int unsigned pp_shift(input vedic_seq_state_t st, input int unsigned w);
        case (st)
            ST_PP1, ST_PP2: return w / 2;
            ST_PP3:         return w;
            default:        return 0;
        endcase
    endfunction

endpackage

// File: rtl/vedic_mul_core.sv
// rtl/vedic_mul_core.sv - combinational NxN Urdhva-Tiryakbhyam multiplier, recursive over 2x2 cells
module vedic_mul_core #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    localparam int PW = 2 * N;

    if (N <= 2) begin : g_cell
        logic [1:0] a2;
        logic [1:0] b2;
        logic [3:0] p4;
        logic       s1;
        logic       c1;

        assign a2    = 2'(a);
        assign b2    = 2'(b);
        // Vertical a0b0, crosswise a1b0+a0b1, vertical a1b1 with the cross carry.
        assign s1    = (a2[1] & b2[0]) ^ (a2[0] & b2[1]);
        assign c1    = (a2[1] & b2[0]) & (a2[0] & b2[1]);
        assign p4[0] = a2[0] & b2[0];
        assign p4[1] = s1;
        assign p4[2] = (a2[1] & b2[1]) ^ c1;
        assign p4[3] = (a2[1] & b2[1]) & c1;
        assign p     = p4[PW-1:0];
    end else begin : g_rec
        localparam int L = N / 2;
        localparam int U = N - L;

        logic [U-1:0]   al;
        logic [U-1:0]   ah;
        logic [U-1:0]   bl;
        logic [U-1:0]   bh;
        logic [2*U-1:0] p_ll;
        logic [2*U-1:0] p_hl;
        logic [2*U-1:0] p_lh;
        logic [2*U-1:0] p_hh;

        assign al = U'(a[L-1:0]);
        assign bl = U'(b[L-1:0]);
        assign ah = a[N-1:L];
        assign bh = b[N-1:L];

        vedic_mul_core #(.N(U)) u_ll (.a(al), .b(bl), .p(p_ll));
        vedic_mul_core #(.N(U)) u_hl (.a(ah), .b(bl), .p(p_hl));
        vedic_mul_core #(.N(U)) u_lh (.a(al), .b(bh), .p(p_lh));
        vedic_mul_core #(.N(U)) u_hh (.a(ah), .b(bh), .p(p_hh));

        assign p = PW'(p_ll)
                 + (PW'(p_hl) << L)
                 + (PW'(p_lh) << L)
                 + (PW'(p_hh) << (2 * L));
    end

endmodule

// File: rtl/vedic_mul_seq.sv
// rtl/vedic_mul_seq.sv - WxW multiplier sequenced over one (W/2)x(W/2) Vedic core; VEDIC_SEQ_ZERO_SKIP_EN enables zero-operand bypass
module vedic_mul_seq
    import vedic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] P
);

    localparam int H  = W / 2;
    localparam int W2 = 2 * W;

    vedic_seq_state_t state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    p_q, p_d;

    logic [H-1:0]     core_a;
    logic [H-1:0]     core_b;
    logic [W-1:0]     core_p;
    logic [W2-1:0]    addend;
    logic [W2-1:0]    acc_sum;

    always_comb begin
        core_a = a_q[H-1:0];
        core_b = b_q[H-1:0];
        case (state_q)
            ST_PP1: core_a = a_q[W-1:H];
            ST_PP2: core_b = b_q[W-1:H];
            ST_PP3: begin
                core_a = a_q[W-1:H];
                core_b = b_q[W-1:H];
            end
            default: ;
        endcase
    end

    vedic_mul_core #(.N(H)) u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    assign addend  = W2'(core_p) << pp_shift(state_q, W);
    assign acc_sum = acc_q + addend;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    state_d = ST_PP0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
                    if (A == '0 || B == '0) begin
                        p_d     = '0;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_PP0: begin
                acc_d   = acc_sum;
                state_d = ST_PP1;
            end
            ST_PP1: begin
                acc_d   = acc_sum;
                state_d = ST_PP2;
            end
            ST_PP2: begin
                acc_d   = acc_sum;
                state_d = ST_PP3;
            end
            ST_PP3: begin
                acc_d   = acc_sum;
                p_d     = acc_sum;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign P         = p_q;

endmodule

// File: tb/tb_vedic_mul_seq.sv
// tb/tb_vedic_mul_seq.sv - randomized self-checking bench for vedic_mul_seq against an arithmetic product model
module tb_vedic_mul_seq;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   P;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [15:0]   last_p = '0;

    vedic_mul_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
        if (a == 8'd0 || b == 8'd0) return 0;
`endif
        return 4;
    endfunction

    // Latency is the number of edges after the acceptance edge until out_valid is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
        int          n;
        int          lat;
        logic [15:0] exp_p;
        exp_p = 16'(a) * 16'(b);
        @(negedge clk);
        A = a;
        B = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("p_hold", P, last_p);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_latency(a, b));
        check("product", P, exp_p);
        last_p = exp_p;
        for (int s = 0; s < stall; s++) begin
            A = ~a;
            B = ~b;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_p", P, last_p);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_p", P, last_p);
    endtask

    task automatic run_b2b();
        logic [7:0]  qa [2];
        logic [7:0]  qb [2];
        int          rc [2];
        logic [15:0] rp [2];
        int          idx;
        int          nres;
        logic        was_ready;
        for (int i = 0; i < 2; i++) begin
            qa[i] = 8'($urandom_range(1, 255));
            qb[i] = 8'($urandom_range(1, 255));
        end
        idx  = 0;
        nres = 0;
        @(negedge clk);
        A = qa[0];
        B = qb[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && nres < 2; c++) begin
            was_ready = in_ready;
            @(posedge clk);
            #1;
            if (was_ready && in_valid) begin
                idx++;
                if (idx >= 2) in_valid = 1'b0;
                else begin
                    A = qa[idx];
                    B = qb[idx];
                end
            end
            if (out_valid && nres < 2) begin
                rc[nres] = cyc;
                rp[nres] = P;
                nres++;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", nres, 2);
        check("b2b_p0", rp[0], 16'(qa[0]) * 16'(qb[0]));
        check("b2b_p1", rp[1], 16'(qa[1]) * 16'(qb[1]));
        check("b2b_spacing", rc[1] - rc[0], 6);
        last_p = 16'(qa[1]) * 16'(qb[1]);
        @(posedge clk);
        #1;
        check("b2b_idle", in_ready, 1);
    endtask

    task automatic run_reset_mid();
        @(negedge clk);
        A = 8'($urandom_range(1, 255));
        B = 8'($urandom_range(1, 255));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_accepted", in_ready, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_p_before", P, last_p);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_p", P, 0);
        check("rst_async_in_ready", in_ready, 1);
        last_p = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_p", P, 0);
        rst_n = 1'b1;

        run_op(8'hA5, 8'h3C, 0);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'h0F, 8'h10, 0);
        run_op(8'hC3, 8'h5A, 3);
        run_op(8'h00, 8'h77, 0);
        run_b2b();
        run_reset_mid();
        run_op(8'h9B, 8'hE7, 0);

        for (int i = 0; i < 12; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
